arp_reply_tx: RTL and testbench
===============================

Name: arp_reply_tx

Overview:
- Downstream consumer of the Ethernet receiver's parsed header; builds and transmits ARP replies.
- On each cycle where the receiver flags a valid ARP request for the FPGA, it captures the sender MAC/IP and emits an ARP reply frame.
- Output is a 64-bit AXI-Stream toward the TX MAC, with a one-deep pending buffer for back-to-back requests.

Parameters:
- FPGA_MAC, 48'h211abcdef112, MAC used as reply source MAC and SHA.
- FPGA_IP, 32'hC0000186, IP used as reply SPA.
- PAD_MIN, 1, 1 = zero-pad frame to 60 bytes (8 beats); 0 = 42-byte frame (6 beats).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_data_head  in  336  parsed 42-byte header; first wire byte at bits [335:328]; SHA at [159:112], SPA at [111:80].
- i_data_head_valid  in  1  header strobe, one cycle.
- i_arp_valid  in  1  header is an ARP request for FPGA_MAC/FPGA_IP; qualified by i_data_head_valid.
- o_tx_axis_tvalid  out  1  stream valid.
- o_tx_axis_tdata  out  64  stream data; lane j (bits 8j+7:8j) = frame byte 8k+j of beat k.
- o_tx_axis_tkeep  out  8  byte enables.
- o_tx_axis_tlast  out  1  last beat.
- i_tx_axis_tready  in  1  downstream ready.
- o_busy  out  1  frame in flight or pending slot occupied.
- o_drop  out  1  one-cycle pulse when a request is discarded.

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_reset).
- Reset: all outputs 0, FSM to IDLE, beat counter 0, pending slot empty.
- Reset mid-frame: frame abandoned, no tlast issued, pending cleared.
- Request strobe: req = i_data_head_valid && i_arp_valid. Capture SHA = i_data_head[159:112] and SPA = i_data_head[111:80].
- Reply byte order (42 bytes):
  - bytes 0–5: SHA (destination MAC); bytes 6–11: FPGA_MAC.
  - bytes 12–21: 08 06 00 01 08 00 06 04 00 02.
  - bytes 22–27: FPGA_MAC; bytes 28–31: FPGA_IP.
  - bytes 32–37: SHA; bytes 38–41: SPA.
  - PAD_MIN=1: bytes 42–59 are 00.
- Beat count and keep:
  - PAD_MIN=1: 8 beats; beats 0–6 keep 8'hFF; beat 7 keep 8'h0F.
  - PAD_MIN=0: 6 beats; beats 0–4 keep 8'hFF; beat 5 keep 8'h03.
  - Unused lanes drive 0. tlast only on the final beat.
- FSM:
  - IDLE: on req, load the active registers and go to SEND. tvalid rises the next cycle (1-cycle latency), with beat 0 presented.
  - SEND: the beat counter advances on tvalid && tready.
  - On handshake of the last beat: if pending is full, promote it to active, reset the counter, and keep tvalid high (zero-gap, beat 0 next cycle). Otherwise go to IDLE and drop tvalid.
- AXI rules: tdata/tkeep/tlast are stable while tvalid && !tready. tvalid never drops before its handshake.
- Pending slot: a req in SEND (or in IDLE while the slot is being promoted) loads the slot.
- Simultaneous events:
  - req in the same cycle as pending promotion: req loads the slot (slot counted as freed).
  - req while slot full and not being promoted: request discarded, o_drop=1 for one cycle, active frame unaffected.
  - req in IDLE in the same cycle as a reset: reset wins.
- o_busy = (state==SEND) || pending_full.
- All outputs are registered.

Test Plan:
- Single request, PAD_MIN=1, tready=1: SHA=001122334455, SPA=C0000101 → tvalid the cycle after the strobe, then 8 consecutive beats:
  - beat 0: 64'h1a21554433221100
  - beat 1: 64'h0100060812f1debc
  - beat 2: 64'h1a21020004060008
  - beat 3: 64'h860100c012f1debc
  - beat 4: 64'h00c0554433221100
  - beat 5: 64'h0000000000000101
  - beats 6–7: 0; beat 7 keep 8'h0F with tlast.
  - o_busy falls after beat 7.
- PAD_MIN=0, same stimulus → 6 beats; beat 5 = 64'h...0101, keep 8'h03, tlast=1.
- Backpressure: tready toggles 1,0,0,1 each beat → every beat held stable during stall; all 8 beats delivered in order exactly once.
- Back-to-back: second request (SHA=AABBCCDDEEFF) arrives at beat 2 of the first → second frame's beat 0 = 64'h1a21ffeeddccbbaa, presented in the cycle immediately after the first tlast handshake with no tvalid gap.
- Overflow: three requests while tready=0 → third produces o_drop pulse; exactly two frames emitted afterwards.
- Non-ARP/ignored strobes: i_data_head_valid=1 with i_arp_valid=0 → no output. Then i_reset asserted at beat 3 of an active frame → next cycle tvalid=0, busy=0; a subsequent request produces a clean frame starting at beat 0.

Source files
------------

// File: rtl/arp_reply_tx.sv
// rtl/arp_reply_tx.sv - builds ARP reply frames from parsed request headers onto a 64-bit stream
// One active frame plus a one-deep pending slot; every output is driven from a register.
module arp_reply_tx #(
    parameter logic [47:0] FPGA_MAC = 48'h211abcdef112,
    parameter logic [31:0] FPGA_IP  = 32'hC0000186,
    parameter bit          PAD_MIN  = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [335:0] i_data_head,
    input  logic         i_data_head_valid,
    input  logic         i_arp_valid,
    output logic         o_tx_axis_tvalid,
    output logic [63:0]  o_tx_axis_tdata,
    output logic [7:0]   o_tx_axis_tkeep,
    output logic         o_tx_axis_tlast,
    input  logic         i_tx_axis_tready,
    output logic         o_busy,
    output logic         o_drop
);

    localparam int         NBEATS    = PAD_MIN ? 8 : 6;
    localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);
    localparam logic [7:0] LAST_KEEP = PAD_MIN ? 8'h0F : 8'h03;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [47:0] act_sha_q, act_sha_d;
    logic [31:0] act_spa_q, act_spa_d;
    logic        pend_full_q, pend_full_d;
    logic [47:0] pend_sha_q, pend_sha_d;
    logic [31:0] pend_spa_q, pend_spa_d;
    logic        drop_d;

    logic        tvalid_q, tvalid_d;
    logic [63:0] tdata_q, tdata_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;
    logic        busy_q, busy_d;
    logic        drop_q;

    logic        req;
    logic        handshake;
    logic [47:0] req_sha;
    logic [31:0] req_spa;
    logic        unused_head_bits;

    assign req              = i_data_head_valid && i_arp_valid;
    assign handshake        = tvalid_q && i_tx_axis_tready;
    assign req_sha          = i_data_head[159:112];
    assign req_spa          = i_data_head[111:80];
    assign unused_head_bits = ^{i_data_head[335:160], i_data_head[79:0]};

    // Frame byte n lands in bits [8n+7:8n], so beat k is simply slice k of the padded frame.
    function automatic logic [63:0] beat_data(input logic [47:0] sha,
                                              input logic [31:0] spa,
                                              input logic [2:0]  beat);
        logic [335:0] hdr;
        logic [511:0] frame;
        hdr   = {sha, FPGA_MAC, 80'h0806_0001_0800_0604_0002, FPGA_MAC, FPGA_IP, sha, spa};
        frame = '0;
        for (int n = 0; n < 42; n++) begin
            frame[8*n +: 8] = hdr[8*(41-n) +: 8];
        end
        return frame[64*beat +: 64];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        act_sha_d   = act_sha_q;
        act_spa_d   = act_spa_q;
        pend_full_d = pend_full_q;
        pend_sha_d  = pend_sha_q;
        pend_spa_d  = pend_spa_q;
        drop_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d   = S_SEND;
                    beat_d    = '0;
                    act_sha_d = req_sha;
                    act_spa_d = req_spa;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    if (beat_q == LAST_BEAT) begin
                        if (pend_full_q) begin
                            act_sha_d   = pend_sha_q;
                            act_spa_d   = pend_spa_q;
                            beat_d      = '0;
                            pend_full_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A slot freed by promotion this cycle can take the new request at once.
        if (state_q == S_SEND && req) begin
            if (!pend_full_d) begin
                pend_full_d = 1'b1;
                pend_sha_d  = req_sha;
                pend_spa_d  = req_spa;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_comb begin
        tvalid_d = (state_d == S_SEND);
        tdata_d  = '0;
        tkeep_d  = '0;
        tlast_d  = 1'b0;
        if (tvalid_d) begin
            tdata_d = beat_data(act_sha_d, act_spa_d, beat_d);
            tkeep_d = (beat_d == LAST_BEAT) ? LAST_KEEP : 8'hFF;
            tlast_d = (beat_d == LAST_BEAT);
        end
        busy_d = tvalid_d || pend_full_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            beat_q      <= '0;
            act_sha_q   <= '0;
            act_spa_q   <= '0;
            pend_full_q <= 1'b0;
            pend_sha_q  <= '0;
            pend_spa_q  <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            act_sha_q   <= act_sha_d;
            act_spa_q   <= act_spa_d;
            pend_full_q <= pend_full_d;
            pend_sha_q  <= pend_sha_d;
            pend_spa_q  <= pend_spa_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign o_tx_axis_tvalid = tvalid_q;
    assign o_tx_axis_tdata  = tdata_q;
    assign o_tx_axis_tkeep  = tkeep_q;
    assign o_tx_axis_tlast  = tlast_q;
    assign o_busy           = busy_q;
    assign o_drop           = drop_q;

endmodule

// File: tb/tb_arp_reply_tx.sv
// tb/tb_arp_reply_tx.sv - self-checking bench for arp_reply_tx (padded and unpadded instances)
module tb_arp_reply_tx;

    localparam logic [47:0] MAC = 48'h211abcdef112;
    localparam logic [31:0] IP  = 32'hC0000186;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, hv, arp, tready;
    logic [335:0] head;
    logic         v1, l1, b1, dr1, v0, l0, b0, dr0;
    logic [63:0]  d1, d0;
    logic [7:0]   k1, k0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] plan [6] = '{64'h1a21554433221100, 64'h0100060812f1debc, 64'h1a21020004060008,
                              64'h860100c012f1debc, 64'h00c0554433221100, 64'h0000000000000101};

    arp_reply_tx #(.PAD_MIN(1'b1)) dut_pad (
        .i_clk(clk), .i_reset(rst), .i_data_head(head), .i_data_head_valid(hv), .i_arp_valid(arp),
        .o_tx_axis_tvalid(v1), .o_tx_axis_tdata(d1), .o_tx_axis_tkeep(k1), .o_tx_axis_tlast(l1),
        .i_tx_axis_tready(tready), .o_busy(b1), .o_drop(dr1));

    arp_reply_tx #(.PAD_MIN(1'b0)) dut_nopad (
        .i_clk(clk), .i_reset(rst), .i_data_head(head), .i_data_head_valid(hv), .i_arp_valid(arp),
        .o_tx_axis_tvalid(v0), .o_tx_axis_tdata(d0), .o_tx_axis_tkeep(k0), .o_tx_axis_tlast(l0),
        .i_tx_axis_tready(tready), .o_busy(b0), .o_drop(dr0));

    // Reference: reply byte n built directly from the field layout of an ARP reply.
    function automatic logic [7:0] exp_byte(input logic [47:0] sha, input logic [31:0] spa, input int n);
        logic [47:0] mac = MAC;
        logic [31:0] ip  = IP;
        logic [79:0] mid = 80'h0806_0001_0800_0604_0002;
        if (n < 6)  return sha[8*(5-n) +: 8];
        if (n < 12) return mac[8*(11-n) +: 8];
        if (n < 22) return mid[8*(21-n) +: 8];
        if (n < 28) return mac[8*(27-n) +: 8];
        if (n < 32) return ip[8*(31-n) +: 8];
        if (n < 38) return sha[8*(37-n) +: 8];
        if (n < 42) return spa[8*(41-n) +: 8];
        return 8'h00;
    endfunction

    // Returns {tlast, tkeep, tdata} expected on beat k.
    function automatic logic [72:0] exp_beat(input logic [47:0] sha, input logic [31:0] spa,
                                             input bit pad, input int k);
        int          nbytes = pad ? 60 : 42;
        logic [63:0] d      = '0;
        logic [7:0]  kp     = '0;
        for (int j = 0; j < 8; j++) begin
            if (8*k + j < nbytes) begin
                d[8*j +: 8] = exp_byte(sha, spa, 8*k + j);
                kp[j]       = 1'b1;
            end
        end
        return {(k == (nbytes + 7) / 8 - 1), kp, d};
    endfunction

    function automatic logic [335:0] rand_head(input logic [47:0] sha, input logic [31:0] spa);
        logic [335:0] h;
        for (int i = 0; i < 10; i++) h[32*i +: 32] = $urandom;
        h[335:320] = 16'($urandom);
        h[159:112] = sha;
        h[111:80]  = spa;
        return h;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; hv = 1'b0; arp = 1'b0; tready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send_req(input logic [47:0] sha, input logic [31:0] spa);
        head = rand_head(sha, spa);
        hv = 1'b1; arp = 1'b1;
        step();
        hv = 1'b0; arp = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; hv = 1'b0; arp = 1'b0; tready = 1'b0; head = '0;
        step();
        step();
        n_cmp++;
        if ({v1, d1, k1, l1, b1, dr1} !== '0) begin
            n_fail++; $display("FAIL reset_pad got v=%b d=%h k=%h l=%b b=%b dr=%b required all 0", v1, d1, k1, l1, b1, dr1);
        end
        n_cmp++;
        if ({v0, d0, k0, l0, b0, dr0} !== '0) begin
            n_fail++; $display("FAIL reset_nopad got v=%b d=%h k=%h l=%b b=%b dr=%b required all 0", v0, d0, k0, l0, b0, dr0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single(input logic [47:0] sha, input logic [31:0] spa, input bit fixed);
        logic [72:0] e;
        do_reset();
        send_req(sha, spa);
        for (int k = 0; k < 8; k++) begin
            e = exp_beat(sha, spa, 1'b1, k);
            n_cmp++;
            if (v1 !== 1'b1 || {l1, k1, d1} !== e || b1 !== 1'b1) begin
                n_fail++; $display("FAIL single_pad beat %0d got v=%b b=%b %h required v=1 b=1 %h", k, v1, b1, {l1, k1, d1}, e);
            end
            if (fixed && k < 6) begin
                n_cmp++;
                if (d1 !== plan[k]) begin
                    n_fail++; $display("FAIL single_plan beat %0d got %h required %h", k, d1, plan[k]);
                end
            end
            if (k < 6) begin
                e = exp_beat(sha, spa, 1'b0, k);
                n_cmp++;
                if (v0 !== 1'b1 || {l0, k0, d0} !== e) begin
                    n_fail++; $display("FAIL single_nopad beat %0d got v=%b %h required v=1 %h", k, v0, {l0, k0, d0}, e);
                end
            end else begin
                n_cmp++;
                if (v0 !== 1'b0 || b0 !== 1'b0) begin
                    n_fail++; $display("FAIL single_nopad_end beat %0d got v=%b b=%b required 0 0", k, v0, b0);
                end
            end
            step();
        end
        n_cmp++;
        if (v1 !== 1'b0 || b1 !== 1'b0) begin
            n_fail++; $display("FAIL single_pad_end got v=%b b=%b required 0 0", v1, b1);
        end
    endtask

    task automatic test_stall(input int mode);
        logic [47:0] sha;
        logic [31:0] spa;
        logic [72:0] cur, held, e;
        logic [3:0]  pat = 4'b1001;
        bit          stalled;
        int          idx, cyc;
        sha = {16'($urandom), $urandom};
        spa = $urandom;
        do_reset();
        send_req(sha, spa);
        stalled = 1'b0; idx = 0; cyc = 0; held = '0;
        while (idx < 8 && cyc < 200) begin
            cur = {l1, k1, d1};
            if (stalled) begin
                n_cmp++;
                if (v1 !== 1'b1 || cur !== held) begin
                    n_fail++; $display("FAIL stall_hold mode %0d cyc %0d got v=%b %h required v=1 %h", mode, cyc, v1, cur, held);
                end
            end
            tready = (mode == 0) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            if (v1 === 1'b1) begin
                if (tready) begin
                    e = exp_beat(sha, spa, 1'b1, idx);
                    n_cmp++;
                    if (cur !== e) begin
                        n_fail++; $display("FAIL stall_beat mode %0d beat %0d got %h required %h", mode, idx, cur, e);
                    end
                    idx++;
                    stalled = 1'b0;
                end else begin
                    held    = cur;
                    stalled = 1'b1;
                end
            end
            step();
            cyc++;
        end
        tready = 1'b1;
        n_cmp++;
        if (idx != 8) begin
            n_fail++; $display("FAIL stall_timeout mode %0d got %0d beats required 8", mode, idx);
        end
        n_cmp++;
        if (v1 !== 1'b0) begin
            n_fail++; $display("FAIL stall_extra mode %0d got v=%b required 0", mode, v1);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] sha_a = 48'h001122334455;
        logic [47:0] sha_b = 48'hAABBCCDDEEFF;
        logic [31:0] spa_a, spa_b;
        logic [72:0] e;
        spa_a = $urandom;
        spa_b = $urandom;
        do_reset();
        send_req(sha_a, spa_a);
        for (int t = 0; t < 16; t++) begin
            if (t == 2) begin
                head = rand_head(sha_b, spa_b);
                hv = 1'b1; arp = 1'b1;
            end
            e = (t < 8) ? exp_beat(sha_a, spa_a, 1'b1, t) : exp_beat(sha_b, spa_b, 1'b1, t - 8);
            n_cmp++;
            if (v1 !== 1'b1 || {l1, k1, d1} !== e) begin
                n_fail++; $display("FAIL b2b cycle %0d got v=%b %h required v=1 %h", t, v1, {l1, k1, d1}, e);
            end
            if (t == 8) begin
                n_cmp++;
                if (d1 !== 64'h1a21ffeeddccbbaa) begin
                    n_fail++; $display("FAIL b2b_second_beat0 got %h required 1a21ffeeddccbbaa", d1);
                end
            end
            step();
            hv = 1'b0; arp = 1'b0;
        end
        n_cmp++;
        if (v1 !== 1'b0 || b1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end got v=%b b=%b required 0 0", v1, b1);
        end
    endtask

    task automatic test_overflow;
        logic [47:0] sha [3];
        logic [31:0] spa [3];
        logic [72:0] e;
        logic [2:0]  drops = 3'b100;
        int          total, cyc, extra;
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sha[i] = {16'($urandom), $urandom};
            spa[i] = $urandom;
        end
        for (int i = 0; i < 3; i++) begin
            head = rand_head(sha[i], spa[i]);
            hv = 1'b1; arp = 1'b1;
            step();
            n_cmp++;
            if (dr1 !== drops[i]) begin
                n_fail++; $display("FAIL overflow_drop req %0d got %b required %b", i, dr1, drops[i]);
            end
        end
        hv = 1'b0; arp = 1'b0;
        step();
        e = exp_beat(sha[0], spa[0], 1'b1, 0);
        n_cmp++;
        if (dr1 !== 1'b0 || v1 !== 1'b1 || {l1, k1, d1} !== e) begin
            n_fail++; $display("FAIL overflow_hold got dr=%b v=%b %h required dr=0 v=1 %h", dr1, v1, {l1, k1, d1}, e);
        end
        tready = 1'b1;
        total = 0; cyc = 0;
        while (total < 16 && cyc < 60) begin
            if (v1 === 1'b1) begin
                e = exp_beat(sha[total / 8], spa[total / 8], 1'b1, total % 8);
                n_cmp++;
                if ({l1, k1, d1} !== e) begin
                    n_fail++; $display("FAIL overflow_beat %0d got %h required %h", total, {l1, k1, d1}, e);
                end
                total++;
            end
            step();
            cyc++;
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (v1 === 1'b1) extra++;
            step();
        end
        n_cmp++;
        if (total != 16 || extra != 0 || b1 !== 1'b0) begin
            n_fail++; $display("FAIL overflow_count got %0d beats +%0d extra busy=%b required 16 +0 busy=0", total, extra, b1);
        end
    endtask

    task automatic test_ignore_reset;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [72:0] e;
        int          seen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            head = rand_head({16'($urandom), $urandom}, $urandom);
            hv = 1'b1; arp = 1'b0;
            step();
            n_cmp++;
            if (v1 !== 1'b0 || b1 !== 1'b0) begin
                n_fail++; $display("FAIL ignore_nonarp %0d got v=%b b=%b required 0 0", i, v1, b1);
            end
        end
        hv = 1'b0; arp = 1'b1;
        step();
        n_cmp++;
        if (v1 !== 1'b0) begin
            n_fail++; $display("FAIL ignore_unqualified got v=%b required 0", v1);
        end
        arp = 1'b0;
        send_req({16'($urandom), $urandom}, $urandom);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                head = rand_head({16'($urandom), $urandom}, $urandom);
                hv = 1'b1; arp = 1'b1;
            end
            step();
            hv = 1'b0; arp = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (v1 !== 1'b0 || b1 !== 1'b0 || l1 !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset got v=%b b=%b l=%b required 0 0 0", v1, b1, l1);
        end
        rst = 1'b1;
        head = rand_head({16'($urandom), $urandom}, $urandom);
        hv = 1'b1; arp = 1'b1;
        step();
        rst = 1'b0; hv = 1'b0; arp = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (v1 === 1'b1 || b1 === 1'b1) seen++;
            step();
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++; $display("FAIL reset_wins got %0d active cycles required 0", seen);
        end
        sha = {16'($urandom), $urandom};
        spa = $urandom;
        send_req(sha, spa);
        for (int k = 0; k < 8; k++) begin
            e = exp_beat(sha, spa, 1'b1, k);
            n_cmp++;
            if (v1 !== 1'b1 || {l1, k1, d1} !== e) begin
                n_fail++; $display("FAIL post_reset beat %0d got v=%b %h required v=1 %h", k, v1, {l1, k1, d1}, e);
            end
            step();
        end
        n_cmp++;
        if (v1 !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_end got v=%b required 0", v1);
        end
    endtask

    initial begin
        test_reset();
        test_single(48'h001122334455, 32'hC0000101, 1'b1);
        test_single({16'($urandom), $urandom}, $urandom, 1'b0);
        test_stall(0);
        test_stall(1);
        test_back_to_back();
        test_overflow();
        test_ignore_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
